// File: rtl/rf_write_port_arbiter.sv
// rf_write_port_arbiter
//   Shares the single register-file write port between the in-order
//   writeback stage (WB) and the multiply/divide unit (MD). MD results are
//   buffered in a small FIFO. A WB write to a register that still has an older
//   MD write queued is held back until that MD write has landed. A FIFO head
//   that has been denied MAX_WAIT times is forced onto the port.
//
// Parameters
//   DEPTH     MD result FIFO entries (power of two, >= 2)
//   MAX_WAIT  denials tolerated before the FIFO head is forced onto the port
//
// Ports
//   clk, reset            clock (posedge) and asynchronous active-high reset
//   wb_valid/addr/data    WB result for this cycle
//   wb_stall              WB must hold its result this cycle (combinational)
//   md_valid/addr/data    MD result offered; transfers when md_ready is high
//   md_ready              FIFO not full
//   rf_we/waddr/wdata     registered register-file write port
//   pending_mask          bit i set iff a valid FIFO entry targets register i
module rf_write_port_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pending_mask
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SW    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [SW-1:0]    WAIT_MAX = SW'(MAX_WAIT);

  // FIFO storage
  logic [4:0]       fifo_addr_q [DEPTH];
  logic [4:0]       fifo_addr_d [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [31:0]      fifo_data_d [DEPTH];
  logic [DEPTH-1:0] fifo_vld_q;
  logic [DEPTH-1:0] fifo_vld_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic        rf_we_q,    rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  // Request / grant signals
  logic wb_req;
  logic head_req;
  logic force_head;
  logic conflict;
  logic grant_head;
  logic grant_wb;
  logic enq;
  logic [31:0] pend;

  // Pending mask is derived from registered entry state only, so it changes
  // on the edge after an enqueue or dequeue.
  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_vld_q[i]) begin
        pend[fifo_addr_q[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    wb_req     = wb_valid && (wb_addr != 5'd0);
    head_req   = (count_q != '0);
    force_head = head_req && (starve_q == WAIT_MAX);
    // A queued MD write is older than the current WB write; it must land first.
    conflict   = wb_req && pend[wb_addr];
    grant_head = force_head || conflict || (head_req && !wb_req);
    grant_wb   = wb_req && !force_head && !conflict;
    md_ready   = (count_q != FULL_CNT);
    // Results for r0 are swallowed at the handshake and never buffered.
    enq        = md_valid && md_ready && (md_addr != 5'd0);
  end

  // FIFO next state
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    fifo_vld_d  = fifo_vld_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (grant_head) begin
      fifo_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + 1'b1;
    end
    if (enq) begin
      fifo_addr_d[wr_ptr_q] = md_addr;
      fifo_data_d[wr_ptr_q] = md_data;
      fifo_vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end

    case ({enq, grant_head})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Starvation counter
  always_comb begin
    starve_d = starve_q;
    if (!head_req || grant_head) begin
      starve_d = '0;
    end else if (starve_q != WAIT_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Output register next state; address/data hold when idle
  always_comb begin
    rf_we_d    = grant_head || grant_wb;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_head) begin
      rf_waddr_d = fifo_addr_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end else if (grant_wb) begin
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      fifo_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      fifo_vld_q  <= fifo_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  assign wb_stall     = wb_req && (force_head || conflict);
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign pending_mask = pend;

endmodule

// File: doc/rf_write_port_arbiter.md
Name: rf_write_port_arbiter

Overview:
Shares the single register-file write port between two writers. The first is the in-order pipeline writeback stage (WB). The second is the multi-cycle multiply/divide unit (MD), whose results are buffered in a small FIFO. The block sits between WB/MD and the register file's write port. It enforces write ordering and prevents MD starvation, stalling WB when required. It also exports a pending-destination mask for the hazard unit.

Parameters:
DEPTH, 2, MD result FIFO entries (power of two, >=2)
MAX_WAIT, 4, cycles a non-empty FIFO head may be denied before it is forced onto the port

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  reset, asynchronous, active-high
wb_valid  in  1  WB has a result this cycle
wb_addr  in  5  WB destination register
wb_data  in  32  WB result
wb_stall  out  1  WB must hold its result this cycle (combinational)
md_valid  in  1  MD result available
md_addr  in  5  MD destination register
md_data  in  32  MD result
md_ready  out  1  FIFO can accept (= not full)
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  5  register-file write address (registered)
rf_wdata  out  32  register-file write data (registered)
pending_mask  out  32  bit i set iff some valid FIFO entry targets register i

Behaviour:
- Reset (async): FIFO empty, pointers and count 0, starve_cnt 0, rf_we=0, rf_waddr=0, rf_wdata=0. pending_mask=0, md_ready=1, wb_stall=0. Asserting reset mid-operation discards all buffered MD results.
- Effective requests: wb_req = wb_valid & (wb_addr!=0); head_req = FIFO non-empty.
- MD handshake: transfer on md_valid & md_ready.
  - A transfer with md_addr==0 is accepted and discarded, not enqueued.
  - There is no bypass; an MD result always spends at least one cycle in the FIFO.
  - When full, md_ready=0 and the FIFO does not enqueue in that cycle even if it dequeues.
- Grant decision (combinational, evaluated each cycle, priority order):
  1. force = head_req & (starve_cnt==MAX_WAIT) -> grant FIFO head.
  2. conflict = wb_req & pending_mask[wb_addr] -> grant FIFO head. The older MD write must land before the younger WB write to the same register.
  3. wb_req -> grant WB.
  4. head_req -> grant FIFO head.
  5. otherwise no grant.
- wb_stall = wb_req & (force | conflict). wb_stall is never asserted for wb_addr==0 or when wb_valid=0.
- Dequeue occurs on the posedge when the FIFO head is granted.
- Output register, posedge after grant:
  - rf_we=1 with the winner's address and data.
  - No grant: rf_we=0; rf_waddr and rf_wdata hold their previous values.
  - Latency is one cycle from grant to port; the register file commits on that cycle's negedge.
- starve_cnt:
  - Cleared when the FIFO is empty or the head is granted.
  - Otherwise increments, saturating at MAX_WAIT.
- pending_mask: OR of one-hot(addr) over valid entries. It updates on the posedge after enqueue or dequeue.
- Simultaneous enqueue and dequeue (not full): count unchanged, both pointers advance, wrap modulo DEPTH.
- rf_waddr is never 0 while rf_we=1.

Test Plan:
- After reset, WB alone: wb_valid=1, wb_addr=5, wb_data=0x1234 for 1 cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; then rf_we=0; wb_stall stays 0.
- MD alone: md_valid=1, md_addr=9, md_data=0xDEADBEEF -> pending_mask=0x200 the next cycle. The head is granted and rf_we=1, rf_waddr=9 one cycle later. pending_mask returns to 0.
- Starvation: enqueue MD to r3, then hold wb_valid=1 to r7 continuously -> WB wins MAX_WAIT=4 cycles. In the 5th cycle wb_stall=1 and r3 is written next cycle. WB resumes the following cycle and starve_cnt=0.
- Ordering conflict: enqueue MD to r8, then immediately wb_valid=1, wb_addr=8 -> wb_stall=1 and the MD write to r8 appears first. The WB write to r8 appears one cycle later.
- Full/addr-0: with DEPTH=2 and wb_valid held to r4 (with MAX_WAIT large enough that no forcing occurs during the check), push MD to r1 and r2 -> md_ready=0, and a third md_valid is not accepted. Separately, MD or WB with addr 0 -> never rf_we, no enqueue, no stall.
- Async reset with 2 FIFO entries pending -> immediately rf_we=0, pending_mask=0, md_ready=1. No buffered write appears after reset is released.
